// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump reader.
// The index-byte feature is selected in the top module by REGDUMP_INDEX_EN.
package regdump_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned REG_IDX_W      = 5;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSel  = 3'd1,
    StIdx  = 3'd2,
    StSend = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Debug read port of the register file plus the outgoing valid/ready byte stream.
// master = the dump reader, slave = register file / byte consumer side.
interface regfile_dump_reader_if;
  import regdump_pkg::*;

  logic [REG_IDX_W-1:0] reg_sel;
  logic [WORD_W-1:0]    reg_data;
  logic                 out_valid;
  logic [BYTE_W-1:0]    out_data;
  logic                 out_ready;

  modport master (
    output reg_sel,
    input  reg_data,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  reg_sel,
    output reg_data,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/regdump_byte_sel.sv
// Picks one byte of the latched word; MSB_FIRST=1 puts bits [31:24] at byte_cnt 0.
module regdump_byte_sel
  import regdump_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [WORD_W-1:0]     word_i,
  input  logic [BYTE_CNT_W-1:0] byte_cnt_i,
  output logic [BYTE_W-1:0]     byte_o
);

  logic [BYTE_CNT_W-1:0] lane;

  always_comb begin
    lane   = MSB_FIRST ? (BYTE_CNT_W'(BYTES_PER_WORD - 1) - byte_cnt_i) : byte_cnt_i;
    byte_o = word_i[{lane, 3'b000} +: BYTE_W];
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Scans registers FIRST_REG..LAST_REG over the debug read port and streams them as bytes.
// Define REGDUMP_INDEX_EN to prefix each word with an index byte {3'b000, reg_sel}.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  regfile_dump_reader_if.master bus_io
);

  localparam logic [REG_IDX_W-1:0] FirstSel = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LastSel  = REG_IDX_W'(LAST_REG);
  localparam logic [BYTE_CNT_W-1:0] LastByte = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
    $error("regfile_dump_reader: need FIRST_REG <= LAST_REG <= 31");
  end

  state_e                state_q, state_d;
  logic [REG_IDX_W-1:0]  reg_sel_q, reg_sel_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]     shadow_q, shadow_d;

  logic                  out_valid;
  logic [BYTE_W-1:0]     out_data;
  logic [BYTE_W-1:0]     word_byte;
  logic                  accept;

  regdump_byte_sel #(
    .MSB_FIRST (MSB_FIRST)
  ) u_byte_sel (
    .word_i     (shadow_q),
    .byte_cnt_i (byte_cnt_q),
    .byte_o     (word_byte)
  );

  assign accept = out_valid && bus_io.out_ready;

  always_comb begin
    state_d    = state_q;
    reg_sel_d  = reg_sel_q;
    byte_cnt_d = byte_cnt_q;
    shadow_d   = shadow_q;
    out_valid  = 1'b0;
    out_data   = '0;

    case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          reg_sel_d = FirstSel;
          state_d   = StSel;
        end
      end
      StSel: begin
        // reg_sel has been stable all cycle, so the combinational read is settled here.
        shadow_d   = bus_io.reg_data;
        byte_cnt_d = '0;
`ifdef REGDUMP_INDEX_EN
        state_d    = StIdx;
`else
        state_d    = StSend;
`endif
      end
`ifdef REGDUMP_INDEX_EN
      StIdx: begin
        out_valid = 1'b1;
        out_data  = {3'b000, reg_sel_q};
        if (accept) begin
          state_d = StSend;
        end
      end
`endif
      StSend: begin
        out_valid = 1'b1;
        out_data  = word_byte;
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LastByte) begin
            if (reg_sel_q == LastSel) begin
              state_d = StDone;
            end else begin
              reg_sel_d = reg_sel_q + 1'b1;
              state_d   = StSel;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides any handshake or transition taken above.
    if (abort_i && state_q != StIdle) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      reg_sel_q  <= '0;
      byte_cnt_q <= '0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      reg_sel_q  <= reg_sel_d;
      byte_cnt_q <= byte_cnt_d;
      shadow_q   <= shadow_d;
    end
  end

  assign bus_io.reg_sel   = reg_sel_q;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_data  = out_data;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a full-range MSB-first instance and a single-register
// LSB-first instance share one register-file model.
module tb_regfile_dump_reader;

`ifdef REGDUMP_INDEX_EN
  localparam int PerReg = 6;
  localparam int BytesPerReg = 5;
`else
  localparam int PerReg = 5;
  localparam int BytesPerReg = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a [2];
  logic        abort_a [2];
  logic        ready_a [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        valid_v [2];
  logic [7:0]  data_v  [2];
  logic [4:0]  sel_v   [2];
  logic [31:0] rf      [32];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] ref_q[$];
  int         done_n;
  int         done_cyc;

  regfile_dump_reader_if if0 ();
  regfile_dump_reader_if if1 ();

  regfile_dump_reader #(
    .FIRST_REG (0),
    .LAST_REG  (31),
    .MSB_FIRST (1'b1)
  ) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_a[0]),
    .abort_i (abort_a[0]),
    .busy_o  (busy_v[0]),
    .done_o  (done_v[0]),
    .bus_io  (if0)
  );

  regfile_dump_reader #(
    .FIRST_REG (7),
    .LAST_REG  (7),
    .MSB_FIRST (1'b0)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_a[1]),
    .abort_i (abort_a[1]),
    .busy_o  (busy_v[1]),
    .done_o  (done_v[1]),
    .bus_io  (if1)
  );

  always #5 clk = ~clk;

  assign if0.reg_data  = (if0.reg_sel == 5'd0) ? 32'h0 : rf[if0.reg_sel];
  assign if1.reg_data  = (if1.reg_sel == 5'd0) ? 32'h0 : rf[if1.reg_sel];
  assign if0.out_ready = ready_a[0];
  assign if1.out_ready = ready_a[1];
  assign valid_v[0]    = if0.out_valid;
  assign valid_v[1]    = if1.out_valid;
  assign data_v[0]     = if0.out_data;
  assign data_v[1]     = if1.out_data;
  assign sel_v[0]      = if0.reg_sel;
  assign sel_v[1]      = if1.reg_sel;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected byte stream built from the register model.
  task automatic build_exp(input int first, input int last, input bit msb);
    logic [31:0] w;
    exp_q.delete();
    for (int r = first; r <= last; r++) begin
      w = (r == 0) ? 32'h0 : rf[r];
`ifdef REGDUMP_INDEX_EN
      exp_q.push_back(8'(r));
`endif
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(msb ? w[8*(3-b) +: 8] : w[8*b +: 8]);
      end
    end
  endtask

  // Starts a dump on DUT d and collects accepted bytes until it returns to idle.
  task automatic dump(input int d, input bit stall, input bit mid_start, input int first);
    bit         prev_stall = 1'b0;
    bit         finished   = 1'b0;
    logic [7:0] prev_data  = 8'h0;
    got_q.delete();
    done_n   = 0;
    done_cyc = -1;
    start_a[d] = 1'b1;
    step();
    start_a[d] = 1'b0;
    check_eq($sformatf("d%0d_sel_first", d), 32'(sel_v[d]), 32'(first));
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(valid_v[d]), 32'd1);
        check_eq("hold_data", 32'(data_v[d]), 32'(prev_data));
      end
      ready_a[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start_a[d] = mid_start && (cyc == 50);
      if (valid_v[d] && ready_a[d]) got_q.push_back(data_v[d]);
      prev_stall = valid_v[d] && !ready_a[d];
      prev_data  = data_v[d];
      if (done_v[d]) begin
        done_n++;
        done_cyc = cyc;
      end
      if (!busy_v[d]) begin
        finished = 1'b1;
        break;
      end
      step();
    end
    ready_a[d] = 1'b0;
    start_a[d] = 1'b0;
    check_eq($sformatf("d%0d_terminated", d), 32'(finished), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int         n_acc;
    bit         hit;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1]  = 32'h12345678;
    rf[3]  = 32'h0000FFFF;
    rf[5]  = 32'h55667788;
    rf[7]  = 32'hA1B2C3D4;
    rf[31] = 32'hDEADBEEF;
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0;
      abort_a[d] = 1'b0;
      ready_a[d] = 1'b0;
    end

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("rst_busy", 32'(busy_v[0]), 32'd0);
    check_eq("rst_done", 32'(done_v[0]), 32'd0);
    check_eq("rst_valid", 32'(valid_v[0]), 32'd0);
    check_eq("rst_data", 32'(data_v[0]), 32'd0);
    check_eq("rst_sel", 32'(sel_v[0]), 32'd0);

    // Reset while the first byte is on offer.
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    step();
`ifdef REGDUMP_INDEX_EN
    step();
`endif
    check_eq("pre_rst_valid", 32'(valid_v[0]), 32'd1);
    rst = 1'b1;
    step();
    check_eq("midrst_busy", 32'(busy_v[0]), 32'd0);
    check_eq("midrst_valid", 32'(valid_v[0]), 32'd0);
    check_eq("midrst_data", 32'(data_v[0]), 32'd0);
    check_eq("midrst_done", 32'(done_v[0]), 32'd0);
    rst = 1'b0;
    step();

    // Full dump without backpressure.
    build_exp(0, 31, 1'b1);
    dump(0, 1'b0, 1'b0, 0);
    compare_stream("full");
    check_eq("full_done_once", 32'(done_n), 32'd1);
    check_eq("full_sel_to_done", 32'(done_cyc), 32'(32 * PerReg));
`ifdef REGDUMP_INDEX_EN
    check_eq("full_r1_idx", 32'(got_q[5]), 32'h01);
    check_eq("full_r1_b0", 32'(got_q[6]), 32'h12);
    check_eq("full_r1_b3", 32'(got_q[9]), 32'h78);
    check_eq("full_r3_idx", 32'(got_q[15]), 32'h03);
    check_eq("full_r3_b1", 32'(got_q[17]), 32'h00);
    check_eq("full_r3_b2", 32'(got_q[18]), 32'hFF);
    check_eq("full_last", 32'(got_q[159]), 32'hEF);
`else
    check_eq("full_r0_b0", 32'(got_q[0]), 32'h00);
    check_eq("full_r1_b0", 32'(got_q[4]), 32'h12);
    check_eq("full_r1_b1", 32'(got_q[5]), 32'h34);
    check_eq("full_r1_b2", 32'(got_q[6]), 32'h56);
    check_eq("full_r1_b3", 32'(got_q[7]), 32'h78);
    check_eq("full_r31_b0", 32'(got_q[124]), 32'hDE);
    check_eq("full_last", 32'(got_q[127]), 32'hEF);
`endif
    ref_q = got_q;

    // Random backpressure must give the same stream.
    dump(0, 1'b1, 1'b0, 0);
    check_eq("bp_len", 32'(got_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("bp_byte%0d", i), 32'(got_q[i]), 32'(ref_q[i]));
    end
    check_eq("bp_done_once", 32'(done_n), 32'd1);

    // Start while busy is ignored.
    dump(0, 1'b0, 1'b1, 0);
    compare_stream("midstart");
    check_eq("midstart_done_once", 32'(done_n), 32'd1);
    check_eq("midstart_sel_to_done", 32'(done_cyc), 32'(32 * PerReg));

    // Abort together with the handshake of byte 2 of r5.
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    n_acc = 0;
    hit   = 1'b0;
    ready_a[0] = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (valid_v[0] && n_acc == 5 * BytesPerReg + (BytesPerReg - 4) + 2) begin
        hit = 1'b1;
        break;
      end
      if (valid_v[0]) n_acc++;
      step();
    end
    check_eq("abort_reached", 32'(hit), 32'd1);
    check_eq("abort_byte", 32'(data_v[0]), 32'h77);
    check_eq("abort_sel", 32'(sel_v[0]), 32'd5);
    abort_a[0] = 1'b1;
    step();
    abort_a[0] = 1'b0;
    ready_a[0] = 1'b0;
    check_eq("abort_busy", 32'(busy_v[0]), 32'd0);
    check_eq("abort_valid", 32'(valid_v[0]), 32'd0);
    check_eq("abort_done", 32'(done_v[0]), 32'd0);
    step();
    check_eq("abort_done_later", 32'(done_v[0]), 32'd0);

    // Single register, LSB first.
    build_exp(7, 7, 1'b0);
    dump(1, 1'b0, 1'b0, 7);
    compare_stream("r7");
    check_eq("r7_done_once", 32'(done_n), 32'd1);
    check_eq("r7_sel_to_done", 32'(done_cyc), 32'(PerReg));
`ifdef REGDUMP_INDEX_EN
    check_eq("r7_idx", 32'(got_q[0]), 32'h07);
    check_eq("r7_b0", 32'(got_q[1]), 32'hD4);
    check_eq("r7_b3", 32'(got_q[4]), 32'hA1);
`else
    check_eq("r7_b0", 32'(got_q[0]), 32'hD4);
    check_eq("r7_b1", 32'(got_q[1]), 32'hC3);
    check_eq("r7_b2", 32'(got_q[2]), 32'hB2);
    check_eq("r7_b3", 32'(got_q[3]), 32'hA1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
